instr_cache_refill_ctrl: RTL and testbench

- Upstream refill engine for the instruction-cache data array (rows of 128-bit qword lines, 4 × 32-bit words each).
- On a miss it issues four sequential 32-bit word reads on the memory bus and assembles the returned beats into one 128-bit line.
- It then writes the line into the addressed row with a one-cycle active-low row write strobe, and signals completion to the fetch stage.

---
 rtl/instr_cache_pkg.sv | 16 +
 rtl/instr_cache_line_assembler.sv | 24 ++
 rtl/instr_cache_refill_ctrl.sv | 149 ++++++++++++++
 tb/tb_instr_cache_refill_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared constants and state encoding for the instruction-cache refill path.
package instr_cache_pkg;

   localparam int BEAT_COUNT       = 4;
   localparam int BEAT_WIDTH       = 32;
   localparam int LINE_WIDTH       = BEAT_COUNT * BEAT_WIDTH;
   localparam int LINE_OFFSET_BITS = 4;
   localparam int BEAT_IDX_BITS    = $clog2(BEAT_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE
   } refill_state_t;

endpackage

// File: rtl/instr_cache_line_assembler.sv
// Collects 32-bit memory beats into one 128-bit cache line register.
module instr_cache_line_assembler
   import instr_cache_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [BEAT_IDX_BITS-1:0] beat_idx,
   input  logic [BEAT_WIDTH-1:0]    beat_data,
   input  logic                     beat_valid,
   input  logic                     clear,
   output logic [LINE_WIDTH-1:0]    line
);

   // NOTE: the line register is a plain datapath register, not a RAM, so it takes
   // the reset value directly and drives a known zero out of reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i || clear) begin
         line <= '0;
      end else if (beat_valid) begin
         line[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
      end
   end

endmodule

// File: rtl/instr_cache_refill_ctrl.sv
// Instruction-cache refill controller: four word reads, line assembly, one-cycle row write.
// Optional watchdog abort enabled by defining REFILL_TIMEOUT_EN.
module instr_cache_refill_ctrl
   import instr_cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 5,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          miss_i,
   input  logic [MEM_ADDR_WIDTH-1:0]     miss_addr_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          error_o,
   output logic                          mem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
   input  logic                          mem_gnt_i,
   input  logic                          mem_rvalid_i,
   input  logic [BEAT_WIDTH-1:0]         mem_rdata_i,
   output logic [LINE_WIDTH-1:0]         flush_data_o,
   output logic [(1<<(ADDR_WIDTH-2))-1:0] flushing_n_o
);

   localparam int ROW_BITS  = ADDR_WIDTH - 2;
   localparam int ROW_COUNT = 1 << ROW_BITS;
   localparam logic [2:0] LAST_BEAT = 3'(BEAT_COUNT - 1);
   localparam logic [2:0] ALL_BEATS = 3'(BEAT_COUNT);
   localparam logic [MEM_ADDR_WIDTH-1:0] LINE_MASK =
      MEM_ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1);

   refill_state_t               state;
   logic [MEM_ADDR_WIDTH-1:0]   base;
   logic [ROW_BITS-1:0]         row;
   logic [2:0]                  req_cnt;
   logic [2:0]                  rsp_cnt;
   logic [2:0]                  req_next;
   logic [MEM_ADDR_WIDTH-1:0]   miss_base;
   logic                        accept;
   logic                        beat_valid;

`ifdef REFILL_TIMEOUT_EN
   localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_BITS-1:0] tmo_cnt;
`else
   assign error_o = 1'b0;
`endif

   assign miss_base  = miss_addr_i & ~LINE_MASK;
   assign req_next   = req_cnt + 3'd1;
   assign accept     = (state == IDLE) && miss_i;
   assign beat_valid = (state == FETCH) && mem_rvalid_i && (rsp_cnt < ALL_BEATS);

   instr_cache_line_assembler u_line (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .beat_idx   (rsp_cnt[BEAT_IDX_BITS-1:0]),
      .beat_data  (mem_rdata_i),
      .beat_valid (beat_valid),
      .clear      (accept),
      .line       (flush_data_o)
   );

   // NOTE: one clocked process holds state, counters and every registered output,
   // all with non-blocking assignments; the last assignment in program order wins.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         base         <= '0;
         row          <= '0;
         req_cnt      <= '0;
         rsp_cnt      <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= '0;
         flushing_n_o <= '1;
`ifdef REFILL_TIMEOUT_EN
         error_o      <= 1'b0;
         tmo_cnt      <= '0;
`endif
      end else begin
         done_o       <= 1'b0;
         flushing_n_o <= '1;
`ifdef REFILL_TIMEOUT_EN
         error_o      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (miss_i) begin
                  base       <= miss_base;
                  row        <= miss_addr_i[ADDR_WIDTH+1:LINE_OFFSET_BITS];
                  req_cnt    <= '0;
                  rsp_cnt    <= '0;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= miss_base;
                  busy_o     <= 1'b1;
                  state      <= FETCH;
`ifdef REFILL_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
               end
            end

            FETCH: begin
               // mem_req_o is high exactly while req_cnt < 4, so req_cnt saturates at 4.
               if (mem_req_o && mem_gnt_i) begin
                  req_cnt <= req_next;
                  if (req_cnt == LAST_BEAT) begin
                     mem_req_o <= 1'b0;
                  end else begin
                     mem_addr_o <= base + (MEM_ADDR_WIDTH'(req_next) << 2);
                  end
               end
               if (beat_valid) begin
                  rsp_cnt <= rsp_cnt + 3'd1;
                  if (rsp_cnt == LAST_BEAT) begin
                     state        <= WRITE;
                     flushing_n_o <= ~(ROW_COUNT'(1) << row);
                  end
               end
`ifdef REFILL_TIMEOUT_EN
               if (mem_rvalid_i) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES)) begin
                  state     <= IDLE;
                  busy_o    <= 1'b0;
                  mem_req_o <= 1'b0;
                  error_o   <= 1'b1;
                  tmo_cnt   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end

            WRITE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Directed self-checking bench for instr_cache_refill_ctrl (ADDR_WIDTH=5, TIMEOUT_CYCLES=10).
module tb_instr_cache_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         miss;
   logic [31:0]  miss_addr;
   logic         busy, done, error;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_gnt, mem_rvalid;
   logic [31:0]  mem_rdata;
   logic [127:0] flush_data;
   logic [7:0]   flushing_n;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_count = 0;
   int err_count = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (done) done_count <= done_count + 1;
      if (error) err_count <= err_count + 1;
   end

   instr_cache_refill_ctrl #(
      .ADDR_WIDTH     (5),
      .MEM_ADDR_WIDTH (32),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .miss_i       (miss),
      .miss_addr_i  (miss_addr),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error),
      .mem_req_o    (mem_req),
      .mem_addr_o   (mem_addr),
      .mem_gnt_i    (mem_gnt),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata),
      .flush_data_o (flush_data),
      .flushing_n_o (flushing_n)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Zero-wait refill with optional mid-fetch miss pulse and optional chained next miss.
   task automatic refill(input logic [31:0] addr,
                         input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3,
                         input bit started, input bit disturb,
                         input bit chain, input logic [31:0] next_addr,
                         output int wcyc);
      logic [31:0] base;
      logic [7:0]  strobe;
      logic [31:0] beats [4];
      beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
      base   = addr & ~32'hF;
      strobe = ~(8'd1 << addr[6:4]);
      if (!started) begin
         miss = 1'b1; miss_addr = addr;
         tick;
         miss = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         check("req_on", mem_req, 1'b1);
         check("req_addr", mem_addr, base + 32'(4 * k));
         check("busy_fetch", busy, 1'b1);
         check("no_strobe_fetch", flushing_n, 8'hFF);
         mem_gnt    = 1'b1;
         mem_rvalid = (k > 0);
         mem_rdata  = (k > 0) ? beats[k-1] : 32'h0;
         if (disturb && k == 2) begin
            miss = 1'b1; miss_addr = 32'h0000_1070;
         end else begin
            miss = 1'b0;
         end
         tick;
      end
      check("req_off", mem_req, 1'b0);
      check("no_done_fetch", done, 1'b0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = b3; miss = 1'b0;
      tick;
      check("strobe", flushing_n, strobe);
      check("line", flush_data, {b3, b2, b1, b0});
      check("busy_write", busy, 1'b1);
      check("no_done_write", done, 1'b0);
      wcyc = cyc;
      mem_rvalid = 1'b0;
      if (chain) begin
         miss = 1'b1; miss_addr = next_addr;
      end
      tick;
      check("done_pulse", done, 1'b1);
      check("strobe_released", flushing_n, 8'hFF);
      check("busy_cleared", busy, 1'b0);
      tick;
      check("done_single", done, 1'b0);
      if (chain) begin
         check("chain_busy", busy, 1'b1);
         check("chain_addr", mem_addr, next_addr & ~32'hF);
         miss = 1'b0;
      end else begin
         check("idle_busy", busy, 1'b0);
      end
      check("no_error", error, 1'b0);
   endtask

   initial begin
      int w0, w1, w2, d0;
      logic [31:0] stall_beats [4];
      rst = 1'b0; miss = 1'b0; miss_addr = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      tick; tick;

      // Reset state
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_req", mem_req, 1'b0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_line", flush_data, 128'h0);
      check("rst_strobe", flushing_n, 8'hFF);
      rst = 1'b1;
      tick;

      // Zero-wait refill: row 3, done at +7
      refill(32'h0000_1234, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0, 1'b0, 1'b0, 32'h0, w0);

      // Stalled grants: three idle grant cycles per request
      stall_beats[0] = 32'hA0; stall_beats[1] = 32'hA1;
      stall_beats[2] = 32'hA2; stall_beats[3] = 32'hA3;
      miss = 1'b1; miss_addr = 32'h0000_1234;
      tick;
      miss = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int s = 0; s < 3; s++) begin
            check("stall_req", mem_req, 1'b1);
            check("stall_addr", mem_addr, 32'h0000_1230 + 32'(4 * k));
            mem_gnt    = 1'b0;
            mem_rvalid = (s == 0 && k > 0);
            mem_rdata  = (s == 0 && k > 0) ? stall_beats[k-1] : 32'h0;
            tick;
         end
         check("stall_req_gnt", mem_req, 1'b1);
         check("stall_addr_gnt", mem_addr, 32'h0000_1230 + 32'(4 * k));
         mem_gnt = 1'b1; mem_rvalid = 1'b0;
         tick;
      end
      check("stall_req_off", mem_req, 1'b0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA3;
      tick;
      check("stall_strobe", flushing_n, 8'b1111_0111);
      check("stall_line", flush_data, 128'h000000A3_000000A2_000000A1_000000A0);
      mem_rvalid = 1'b0;
      tick;
      check("stall_done", done, 1'b1);
      tick;
      check("stall_done_single", done, 1'b0);
      check("stall_idle", busy, 1'b0);

      // Disturbances: stray rvalid in IDLE, then a foreign miss pulse mid-fetch
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick;
      mem_rvalid = 1'b0;
      check("stray_busy", busy, 1'b0);
      check("stray_strobe", flushing_n, 8'hFF);
      d0 = done_count;
      refill(32'h0000_1010, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b0, 1'b1, 1'b0, 32'h0, w0);
      tick; tick; tick;
      check("disturb_one_done", 32'(done_count - d0), 32'd1);
      check("disturb_idle", busy, 1'b0);
      check("disturb_no_strobe", flushing_n, 8'hFF);

      // Reset after the 2nd beat, then two late responses
      d0 = done_count;
      miss = 1'b1; miss_addr = 32'h0000_2040;
      tick;
      miss = 1'b0; mem_gnt = 1'b1;
      tick;
      mem_rvalid = 1'b1; mem_rdata = 32'hC0;
      tick;
      mem_rdata = 32'hC1;
      tick;
      rst = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
      tick;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_req", mem_req, 1'b0);
      check("mid_rst_addr", mem_addr, 32'h0);
      check("mid_rst_line", flush_data, 128'h0);
      rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hC2;
      tick;
      check("late_beat_strobe", flushing_n, 8'hFF);
      check("late_beat_busy", busy, 1'b0);
      mem_rdata = 32'hC3;
      tick;
      mem_rvalid = 1'b0;
      check("late_beat2_strobe", flushing_n, 8'hFF);
      tick;
      check("mid_rst_no_done", 32'(done_count - d0), 32'd0);
      refill(32'h0000_2040, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 1'b0, 1'b0, 1'b0, 32'h0, w0);

      // Back-to-back misses: second refill accepted in the done cycle
      refill(32'h0000_1050, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b0, 1'b0, 1'b1, 32'h0000_1060, w1);
      refill(32'h0000_1060, 32'h10, 32'h11, 32'h12, 32'h13, 1'b1, 1'b0, 1'b0, 32'h0, w2);
      check("b2b_spacing", 32'(w2 - w1), 32'd7);

`ifdef REFILL_TIMEOUT_EN
      // Timeout: three beats return, the fourth never does
      d0 = done_count;
      w0 = err_count;
      miss = 1'b1; miss_addr = 32'h0000_3000;
      tick;
      miss = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_gnt    = 1'b1;
         mem_rvalid = (k > 0);
         mem_rdata  = 32'h50 + 32'(k);
         tick;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      w1 = 0;
      for (int i = 0; i < 30; i++) begin
         if (flushing_n !== 8'hFF) w1++;
         tick;
      end
      check("tmo_error_once", 32'(err_count - w0), 32'd1);
      check("tmo_no_strobe", 32'(w1), 32'd0);
      check("tmo_no_done", 32'(done_count - d0), 32'd0);
      check("tmo_req_off", mem_req, 1'b0);
      check("tmo_idle", busy, 1'b0);
`else
      check("no_error_pulses", 32'(err_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
